// File: rtl/cia_serial_sub32_pkg.sv
// Shared definitions for the serial carry-increment subtractor:
// FSM state encodings and default operand/slice widths.
package cia_serial_sub32_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cia_serial_sub32_cia8.sv
// Carry-increment slice: the upper half is summed without carry and then
// incremented by the lower half's carry, so the carry path stays short.
module cia_serial_sub32_cia8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int H = W / 2;
  localparam int U = W - H;

  logic [H:0]   lo;
  logic [U:0]   hi_raw;
  logic [U-1:0] hi;

  always_comb begin
    lo     = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
    hi_raw = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]};
    hi     = hi_raw[U-1:0] + {{(U-1){1'b0}}, lo[H]};
    // The increment only carries out when the raw upper sum is all ones.
    cout   = hi_raw[U] | (lo[H] & (&hi_raw[U-1:0]));
    sum    = {hi, lo[H-1:0]};
  end

endmodule

// File: rtl/cia_serial_sub32.sv
// Multi-cycle subtractor D = A - B - Bin, computed as A + ~B + ~Bin one slice
// per cycle through a single shared carry-increment slice.
module cia_serial_sub32
  import cia_serial_sub32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   bn_q, bn_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bout_q, bout_d;
  logic               v_q, v_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_bn;
  logic [SLICE-1:0]   slice_sum;
  logic               slice_cout;

  assign slice_a  = a_q[idx_q*SLICE +: SLICE];
  assign slice_bn = bn_q[idx_q*SLICE +: SLICE];

  cia_serial_sub32_cia8 #(.W(SLICE)) u_cia8bit (
    .a    (slice_a),
    .b    (slice_bn),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    bn_d        = bn_q;
    d_d         = d_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    bout_d      = bout_q;
    v_d         = v_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = A;
          bn_d       = ~B;
          carry_d    = ~Bin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        d_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Subtrahend sign is the inverse of the stored ~B sign bit.
          bout_d      = ~slice_cout;
          v_d         = (a_q[WIDTH-1] ^ ~bn_q[WIDTH-1]) & (slice_sum[SLICE-1] ^ a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      bn_q        <= '0;
      d_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      bout_q      <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bn_q        <= bn_d;
      d_q         <= d_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      bout_q      <= bout_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_cia_serial_sub32.sv
// Bench for cia_serial_sub32: arithmetic reference model plus handshake
// timing model, directed literal vectors, randomized operations and reset abort.
module tb_cia_serial_sub32;

  localparam int NSLICE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Bin = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] D;
  logic        Bout;
  logic        V;

  int n_tests = 0;
  int n_fail  = 0;

  cia_serial_sub32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from plain unsigned and signed integer subtraction.
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                  output logic [31:0] d, output logic bout, output logic v);
    logic [32:0] wide;
    longint      sres;
    wide = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    d    = wide[31:0];
    bout = wide[32];
    sres = longint'($signed(a)) - longint'($signed(b)) - longint'({31'd0, bin});
    v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
  endfunction

  // Handshake model: 0 = idle, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [31:0] m_d     = '0;
  logic        m_bout  = 1'b0;
  logic        m_v     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] td;
    logic        tb_b, tv;
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          ref_sub(A, B, Bin, td, tb_b, tv);
          m_d     <= td;
          m_bout  <= tb_b;
          m_v     <= tv;
          m_cnt   <= 0;
          m_phase <= 1;
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == NSLICE - 1) m_phase <= 2;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, m_phase == 0);
      check("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        check("D", D, m_d);
        check("Bout", Bout, m_bout);
        check("V", V, m_v);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin, input int hold,
                        output int lat, output logic [31:0] d_got, output logic bout_got, output logic v_got);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", in_ready, 1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
    lat = lat - 1;
    d_got = D; bout_got = Bout; v_got = V;
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'($urandom_range(0, 1));
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        v;
  } vec_t;

  vec_t vecs [5] = '{
    '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1},
    '{32'h0000_FF00, 32'h0000_00FF, 1'b0, 32'h0000_FE01, 1'b0, 1'b0},
    '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] dg, ed;
    logic        bg, vg, eb, ev;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_Bout", Bout, 0);
    check("rst_V", V, 0);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, lat, dg, bg, vg);
      check($sformatf("vec%0d_D", i), dg, vecs[i].d);
      check($sformatf("vec%0d_Bout", i), bg, vecs[i].bout);
      check($sformatf("vec%0d_V", i), vg, vecs[i].v);
      check($sformatf("vec%0d_latency", i), lat, NSLICE);
    end

    // Stall in DONE for 10 cycles, then confirm return to idle after the pulse.
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 10, lat, dg, bg, vg);
    check("stall_D", D === dg ? 1 : 0, 1);
    check("stall_D_value", dg, 32'hCC79_6877);
    check("stall_in_ready_after", in_ready, 1);
    check("stall_out_valid_after", out_valid, 0);

    // Abort with reset while slice index 2 is pending.
    @(negedge clk);
    A = 32'h0F0F_0F0F; B = 32'h0101_0101; Bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_D", D, 0);
    check("abort_Bout", Bout, 0);
    check("abort_V", V, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_out_valid", out_valid, 0);
    end
    run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1, lat, dg, bg, vg);
    check("after_abort_D", dg, 32'h0E0E_0E0E);
    check("after_abort_latency", lat, NSLICE);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic        rbin;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      rbin = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbin, $urandom_range(0, 3), lat, dg, bg, vg);
      ref_sub(ra, rb, rbin, ed, eb, ev);
      check("rand_D", dg, ed);
      check("rand_Bout", bg, eb);
      check("rand_V", vg, ev);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
